// File: rtl/bluejay_pkg.sv
// Shared types and constants for the Bluejay command controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package bluejay_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_DHI,
    ST_DLO,
    ST_SHIFT,
    ST_ACK,
    ST_ACK_WAIT
  } state_t;

  localparam logic [7:0] RESP_ACK      = 8'h06;
  localparam logic [7:0] RESP_NAK      = 8'h15;
  localparam int         FRAME_BITS    = 24;
  localparam int         RSVD_ADDR_BIT = 7;
  // 48 SCK edges plus the closing SEN rise, each one half-period apart.
  localparam int         FRAME_EDGES   = 2 * FRAME_BITS + 1;

endpackage

// File: rtl/bluejay_spi_shift.sv
// Shifts one 24-bit frame MSB first over SEN/SCK/SDAT (SEN active low, SCK idle low).
// Latency: SEN falls the cycle after i_Start, rises 49*H cycles later with o_Done.
// Backpressure: i_Start is ignored while a frame is in flight.
// Ports: i_Clock/i_Reset, i_Start + i_Frame (frame load), o_SEN/o_SCK/o_SDAT (pins),
//        o_Last (combinational: frame ends at the next edge), o_Done (one-cycle strobe).
module bluejay_spi_shift
  import bluejay_pkg::*;
#(
  parameter int CLKS_PER_HALF_SCK = 25
) (
  input  logic                  i_Clock,
  input  logic                  i_Reset,
  input  logic                  i_Start,
  input  logic [FRAME_BITS-1:0] i_Frame,
  output logic                  o_SEN,
  output logic                  o_SCK,
  output logic                  o_SDAT,
  output logic                  o_Last,
  output logic                  o_Done
);

  localparam int             DW      = (CLKS_PER_HALF_SCK > 1) ? $clog2(CLKS_PER_HALF_SCK) : 1;
  localparam logic [DW-1:0]  DIV_MAX = DW'(CLKS_PER_HALF_SCK - 1);

  logic                  active_q, active_d;
  logic [DW-1:0]         div_q, div_d;
  logic [5:0]            edge_q, edge_d;
  // Bit 23 goes straight to SDAT on load, so only the remaining 23 bits are held.
  logic [FRAME_BITS-2:0] sr_q, sr_d;
  logic                  sen_q, sen_d;
  logic                  sck_q, sck_d;
  logic                  sdat_q, sdat_d;
  logic                  done_q, done_d;
  logic                  tick;
  logic [5:0]            edge_nxt;

  always_comb begin
    active_d = active_q;
    div_d    = div_q;
    edge_d   = edge_q;
    sr_d     = sr_q;
    sen_d    = sen_q;
    sck_d    = sck_q;
    sdat_d   = sdat_q;
    done_d   = 1'b0;
    tick     = active_q && (div_q == DIV_MAX);
    edge_nxt = edge_q + 6'd1;
    o_Last   = tick && (edge_nxt == 6'(FRAME_EDGES));

    if (i_Start && !active_q) begin
      active_d = 1'b1;
      div_d    = '0;
      edge_d   = '0;
      sr_d     = i_Frame[FRAME_BITS-2:0];
      sen_d    = 1'b0;
      sck_d    = 1'b0;
      sdat_d   = i_Frame[FRAME_BITS-1];
    end else if (active_q) begin
      div_d = tick ? '0 : div_q + 1'b1;
      if (tick) begin
        edge_d = edge_nxt;
        if (edge_nxt == 6'(FRAME_EDGES)) begin
          active_d = 1'b0;
          sen_d    = 1'b1;
          sck_d    = 1'b0;
          sdat_d   = 1'b0;
          done_d   = 1'b1;
        end else if (edge_nxt[0]) begin
          sck_d = 1'b1;
        end else begin
          // Falling edge: present the next bit so it is stable over the next rise.
          sck_d  = 1'b0;
          sdat_d = sr_q[FRAME_BITS-2];
          sr_d   = {sr_q[FRAME_BITS-3:0], 1'b0};
        end
      end
    end
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      active_q <= 1'b0;
      div_q    <= '0;
      edge_q   <= '0;
      sr_q     <= '0;
      sen_q    <= 1'b1;
      sck_q    <= 1'b0;
      sdat_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      active_q <= active_d;
      div_q    <= div_d;
      edge_q   <= edge_d;
      sr_q     <= sr_d;
      sen_q    <= sen_d;
      sck_q    <= sck_d;
      sdat_q   <= sdat_d;
      done_q   <= done_d;
    end
  end

  assign o_SEN  = sen_q;
  assign o_SCK  = sck_q;
  assign o_SDAT = sdat_q;
  assign o_Done = done_q;

endmodule

// File: rtl/bluejay_cmd_ctrl.sv
// Parses SYNC/ADDR/DATA_HI/DATA_LO packets from uart_rx, writes them to Bluejay, answers ACK/NAK.
// Latency: SPI frame starts the cycle after DATA_LO; response strobe the cycle after frame end.
// Backpressure: response held until uart_tx idle; bytes arriving outside header parsing are dropped.
// Ports: i_Rx_DV/i_Rx_Byte (uart_rx), o_Tx_DV/o_Tx_Byte/i_Tx_Active/i_Tx_Done (uart_tx),
//        o_SEN/o_SCK/o_SDAT (Bluejay pins), o_Busy, o_Write_Count (completed writes, wraps).
module bluejay_cmd_ctrl
  import bluejay_pkg::*;
#(
  parameter int         CLKS_PER_HALF_SCK = 25,
  parameter int         TIMEOUT_CLKS      = 434000,
  parameter logic [7:0] SYNC_BYTE         = 8'hA5
) (
  input  logic        i_Clock,
  input  logic        i_Reset,
  input  logic        i_Rx_DV,
  input  logic [7:0]  i_Rx_Byte,
  output logic        o_Tx_DV,
  output logic [7:0]  o_Tx_Byte,
  input  logic        i_Tx_Active,
  input  logic        i_Tx_Done,
  output logic        o_SEN,
  output logic        o_SCK,
  output logic        o_SDAT,
  output logic        o_Busy,
  output logic [15:0] o_Write_Count
);

  localparam int            TW        = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS + 1) : 1;
  // Counting down from TIMEOUT_CLKS-1 to 0 spans exactly TIMEOUT_CLKS idle cycles.
  localparam logic [TW-1:0] TO_RELOAD = TW'(TIMEOUT_CLKS - 1);

  state_t          state_q, state_d;
  logic [TW-1:0]   to_q, to_d;
  logic [7:0]      addr_q, addr_d;
  logic [7:0]      dhi_q, dhi_d;
  logic [7:0]      resp_q, resp_d;
  logic            tx_dv_q, tx_dv_d;
  logic            busy_q, busy_d;
  logic [15:0]     write_count_q, write_count_d;

  logic                  spi_start;
  logic [FRAME_BITS-1:0] spi_frame;
  logic                  spi_last;
  logic                  spi_done;

  always_comb begin
    state_d       = state_q;
    to_d          = to_q;
    addr_d        = addr_q;
    dhi_d         = dhi_q;
    resp_d        = resp_q;
    tx_dv_d       = 1'b0;
    write_count_d = write_count_q;
    spi_start     = 1'b0;
    spi_frame     = {addr_q, dhi_q, i_Rx_Byte};

    case (state_q)
      ST_IDLE: begin
        if (i_Rx_DV && (i_Rx_Byte == SYNC_BYTE)) begin
          state_d = ST_ADDR;
          to_d    = TO_RELOAD;
        end
      end
      ST_ADDR: begin
        if (i_Rx_DV) begin
          addr_d  = i_Rx_Byte;
          state_d = ST_DHI;
          to_d    = TO_RELOAD;
        end else if (to_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          to_d = to_q - 1'b1;
        end
      end
      ST_DHI: begin
        if (i_Rx_DV) begin
          dhi_d   = i_Rx_Byte;
          state_d = ST_DLO;
          to_d    = TO_RELOAD;
        end else if (to_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          to_d = to_q - 1'b1;
        end
      end
      ST_DLO: begin
        if (i_Rx_DV) begin
          if (addr_q[RSVD_ADDR_BIT]) begin
            resp_d  = RESP_NAK;
            state_d = ST_ACK;
            tx_dv_d = !i_Tx_Active;
          end else begin
            spi_start = 1'b1;
            state_d   = ST_SHIFT;
          end
        end else if (to_q == '0) begin
          state_d = ST_IDLE;
        end else begin
          to_d = to_q - 1'b1;
        end
      end
      ST_SHIFT: begin
        if (spi_done) begin
          resp_d  = RESP_ACK;
          state_d = ST_ACK;
          tx_dv_d = !i_Tx_Active;
        end
      end
      ST_ACK: begin
        // The strobe is raised on the way into (or while waiting in) ACK so it is
        // a registered output; once it has been shown for a cycle, move on.
        if (tx_dv_q) begin
          state_d = ST_ACK_WAIT;
        end else begin
          tx_dv_d = !i_Tx_Active;
        end
      end
      ST_ACK_WAIT: begin
        if (i_Tx_Done) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    // Count lands in the same cycle SEN rises.
    if (spi_last) begin
      write_count_d = write_count_q + 16'd1;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge i_Clock or posedge i_Reset) begin
    if (i_Reset) begin
      state_q       <= ST_IDLE;
      to_q          <= '0;
      addr_q        <= '0;
      dhi_q         <= '0;
      resp_q        <= 8'h00;
      tx_dv_q       <= 1'b0;
      busy_q        <= 1'b0;
      write_count_q <= 16'h0000;
    end else begin
      state_q       <= state_d;
      to_q          <= to_d;
      addr_q        <= addr_d;
      dhi_q         <= dhi_d;
      resp_q        <= resp_d;
      tx_dv_q       <= tx_dv_d;
      busy_q        <= busy_d;
      write_count_q <= write_count_d;
    end
  end

  bluejay_spi_shift #(
    .CLKS_PER_HALF_SCK(CLKS_PER_HALF_SCK)
  ) u_spi (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .i_Start (spi_start),
    .i_Frame (spi_frame),
    .o_SEN   (o_SEN),
    .o_SCK   (o_SCK),
    .o_SDAT  (o_SDAT),
    .o_Last  (spi_last),
    .o_Done  (spi_done)
  );

  assign o_Tx_DV       = tx_dv_q;
  assign o_Tx_Byte     = resp_q;
  assign o_Busy        = busy_q;
  assign o_Write_Count = write_count_q;

endmodule

// File: tb/tb_bluejay_cmd_ctrl.sv
// Scoreboard bench for bluejay_cmd_ctrl: stimulus pushes expected SPI frames and
// response bytes; monitors pop and compare as the DUT emits them.
// Includes a small uart_tx stand-in driving i_Tx_Active/i_Tx_Done.
module tb_bluejay_cmd_ctrl;

  localparam int H  = 2;
  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_dv = 1'b0;
  logic [7:0]  rx_byte = 8'h00;
  logic        tx_dv;
  logic [7:0]  tx_byte;
  logic        tx_active;
  logic        tx_done;
  logic        sen, sck, sdat, busy;
  logic [15:0] wc;

  logic hold_busy    = 1'b0;
  logic model_active = 1'b0;
  logic model_done   = 1'b0;
  assign tx_active = model_active | hold_busy;
  assign tx_done   = model_done;

  int checks = 0;
  int errors = 0;
  int tx_seen = 0;
  logic [23:0] exp_frame[$];
  logic [7:0]  exp_tx[$];

  always #5 clk = ~clk;

  bluejay_cmd_ctrl #(
    .CLKS_PER_HALF_SCK(H),
    .TIMEOUT_CLKS(TO),
    .SYNC_BYTE(8'hA5)
  ) dut (
    .i_Clock(clk), .i_Reset(rst),
    .i_Rx_DV(rx_dv), .i_Rx_Byte(rx_byte),
    .o_Tx_DV(tx_dv), .o_Tx_Byte(tx_byte),
    .i_Tx_Active(tx_active), .i_Tx_Done(tx_done),
    .o_SEN(sen), .o_SCK(sck), .o_SDAT(sdat),
    .o_Busy(busy), .o_Write_Count(wc)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    rx_dv = 1'b1; rx_byte = b;
    @(posedge clk); #1;
    rx_dv = 1'b0;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    while (busy && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("wait_idle_busy", 32'(busy), 32'd0);
  endtask

  // SPI monitor: rebuilds each frame from SDAT on SCK rises.
  initial begin
    logic sen_p, sck_p, sdat_p, in_frame, glitch;
    int len, nbits;
    logic [23:0] got, e;
    sen_p = 1'b1; sck_p = 1'b0; sdat_p = 1'b0; in_frame = 1'b0; glitch = 1'b0;
    len = 0; nbits = 0; got = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        in_frame = 1'b0;
      end else begin
        if (sen_p && !sen) begin
          in_frame = 1'b1; len = 0; nbits = 0; got = '0; glitch = 1'b0;
        end
        if (in_frame) begin
          if (!sen) begin
            len++;
            if (sck && !sck_p) begin
              got = {got[22:0], sdat};
              nbits++;
            end
            if (!(sen_p && !sen) && (sdat !== sdat_p) && !(sck_p && !sck)) glitch = 1'b1;
          end else begin
            in_frame = 1'b0;
            if (exp_frame.size() == 0) begin
              checks++; errors++;
              $display("FAIL spi_unexpected: got frame 0x%06h, expected none", got);
            end else begin
              e = exp_frame.pop_front();
              chk("spi_frame", 32'(got), 32'(e));
              chk("sen_low_cycles", 32'(len), 32'(49 * H));
              chk("sck_rises", 32'(nbits), 32'd24);
              chk("sdat_change_off_fall", 32'(glitch), 32'd0);
              chk("sdat_idle", 32'(sdat), 32'd0);
            end
          end
        end
      end
      sen_p = sen; sck_p = sck; sdat_p = sdat;
    end
  end

  // Response monitor plus uart_tx stand-in.
  initial begin
    logic [7:0] b;
    logic moved;
    forever begin
      @(negedge clk);
      if (!rst && tx_dv) begin
        tx_seen++;
        chk("tx_dv_while_active", 32'(tx_active), 32'd0);
        if (exp_tx.size() == 0) begin
          checks++; errors++;
          $display("FAIL tx_unexpected: got byte 0x%02h, expected none", tx_byte);
        end else begin
          chk("tx_byte", 32'(tx_byte), 32'(exp_tx.pop_front()));
        end
        b = tx_byte; moved = 1'b0;
        model_active = 1'b1;
        repeat (8) begin
          @(negedge clk);
          if (tx_byte !== b) moved = 1'b1;
        end
        model_active = 1'b0; model_done = 1'b1;
        @(negedge clk);
        model_done = 1'b0;
        chk("tx_byte_held", 32'(moved), 32'd0);
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int saved, n;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_sen", 32'(sen), 32'd1);
    chk("rst_sck", 32'(sck), 32'd0);
    chk("rst_sdat", 32'(sdat), 32'd0);
    chk("rst_tx_dv", 32'(tx_dv), 32'd0);
    chk("rst_tx_byte", 32'(tx_byte), 32'h00);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wc", 32'(wc), 32'd0);
    rst = 1'b0;

    // Basic write
    exp_frame.push_back(24'h123456); exp_tx.push_back(8'h06);
    send(8'hA5);
    chk("busy_after_sync", 32'(busy), 32'd1);
    send(8'h12); send(8'h34); send(8'h56);
    chk("sen_low_at_t0", 32'(sen), 32'd0);
    chk("sdat_bit23_at_t0", 32'(sdat), 32'd0);
    wait_idle(400);
    chk("wc_after_basic", 32'(wc), 32'd1);

    // Reserved address -> NAK with no SPI activity
    exp_tx.push_back(8'h15);
    send(8'hA5); send(8'h80); send(8'h00); send(8'h01);
    chk("nak_tx_dv_at_n1", 32'(tx_dv), 32'd1);
    chk("nak_sen_high", 32'(sen), 32'd1);
    wait_idle(100);
    chk("wc_after_nak", 32'(wc), 32'd1);

    // Garbage, then a timed-out partial packet, then a good one
    send(8'h00); send(8'hFF);
    chk("garbage_idle", 32'(busy), 32'd0);
    send(8'hA5); send(8'h12);
    repeat (TO + 1) @(posedge clk);
    #1;
    chk("timeout_idle", 32'(busy), 32'd0);
    send(8'h34); send(8'h56);
    chk("stale_bytes_idle", 32'(busy), 32'd0);
    exp_frame.push_back(24'h010203); exp_tx.push_back(8'h06);
    send(8'hA5); send(8'h01); send(8'h02); send(8'h03);
    wait_idle(400);
    chk("wc_after_timeout", 32'(wc), 32'd2);

    // uart_tx busy holds off the response
    exp_frame.push_back(24'h2ABEEF); exp_tx.push_back(8'h06);
    send(8'hA5); send(8'h2A); send(8'hBE);
    hold_busy = 1'b1;
    send(8'hEF);
    n = 0;
    while (!sen && n < 200) begin @(negedge clk); n++; end
    chk("frame_end_seen", 32'(sen), 32'd1);
    saved = tx_seen;
    repeat (500) @(negedge clk);
    chk("tx_withheld", 32'(tx_seen), 32'(saved));
    chk("busy_while_withheld", 32'(busy), 32'd1);
    hold_busy = 1'b0;
    wait_idle(100);
    chk("tx_single_pulse", 32'(tx_seen), 32'(saved + 1));
    chk("wc_after_busy_tx", 32'(wc), 32'd3);

    // SYNC dropped during SHIFT; trailing bytes without SYNC do nothing
    exp_frame.push_back(24'h334455); exp_tx.push_back(8'h06);
    send(8'hA5); send(8'h33); send(8'h44); send(8'h55);
    repeat (20) @(posedge clk);
    send(8'hA5);
    wait_idle(400);
    send(8'h01); send(8'h02); send(8'h03);
    chk("dropped_sync_idle", 32'(busy), 32'd0);
    chk("wc_after_drop", 32'(wc), 32'd4);

    // Counter wrap
    force dut.write_count_q = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;
    release dut.write_count_q;
    @(posedge clk); #1;
    chk("wc_preload", 32'(wc), 32'hFFFF);
    exp_frame.push_back(24'h050607); exp_tx.push_back(8'h06);
    send(8'hA5); send(8'h05); send(8'h06); send(8'h07);
    wait_idle(400);
    chk("wc_wrap", 32'(wc), 32'h0000);

    // Reset mid-frame
    saved = tx_seen;
    send(8'hA5); send(8'h12); send(8'h34); send(8'h56);
    repeat (20) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_sen", 32'(sen), 32'd1);
    chk("midrst_sck", 32'(sck), 32'd0);
    chk("midrst_busy", 32'(busy), 32'd0);
    chk("midrst_tx_dv", 32'(tx_dv), 32'd0);
    chk("midrst_wc", 32'(wc), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (200) @(negedge clk);
    chk("midrst_no_tx", 32'(tx_seen), 32'(saved));
    chk("midrst_sen_idle", 32'(sen), 32'd1);
    chk("midrst_busy_idle", 32'(busy), 32'd0);

    chk("frames_outstanding", 32'(exp_frame.size()), 32'd0);
    chk("tx_outstanding", 32'(exp_tx.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bluejay_cmd_ctrl.md
# bluejay_cmd_ctrl

UART-to-Bluejay register-write controller. Consumes bytes from the existing `uart_rx` instance and parses 4-byte host command packets. It shifts each valid packet out to the Bluejay SLM over its 3-wire write interface (SEN/SCK/SDAT), then queues a single ACK or NAK byte into the existing `uart_tx` instance. It sits in `top` between the UART pair and the Bluejay pins, replacing the current RX→TX loopback.

## Interface
Parameters:
- `CLKS_PER_HALF_SCK`, default 25: sys_clk cycles per SCK half-period (H). Must be ≥ 1. The default gives 1 MHz SCK at 50 MHz.
- `TIMEOUT_CLKS`, default 434000: maximum idle gap between bytes of one packet, in cycles. Must be ≥ 1.
- `SYNC_BYTE`, default 8'hA5: packet header.

Ports:
- `i_Clock`  in  1: sys_clk. Single clock domain.
- `i_Reset`  in  1: asynchronous, active-high reset.
- `i_Rx_DV`  in  1: one-cycle strobe from `uart_rx`.
- `i_Rx_Byte`  in  8: received byte, valid while `i_Rx_DV` is high.
- `o_Tx_DV`  out  1: one-cycle start strobe to `uart_tx`.
- `o_Tx_Byte`  out  8: response byte, held stable from the `o_Tx_DV` cycle until `i_Tx_Done`.
- `i_Tx_Active`  in  1: `uart_tx` busy.
- `i_Tx_Done`  in  1: `uart_tx` one-cycle completion strobe.
- `o_SEN`  out  1: Bluejay enable, active low.
- `o_SCK`  out  1: Bluejay serial clock, idle low.
- `o_SDAT`  out  1: Bluejay serial data, MSB first.
- `o_Busy`  out  1: high whenever the FSM is not in IDLE.
- `o_Write_Count`  out  16: count of completed SPI writes. Wraps from 16'hFFFF to 0.

## Operation
- Packet format: SYNC_BYTE, ADDR, DATA_HI, DATA_LO.
- FSM states: IDLE, ADDR, DHI, DLO, SHIFT, ACK, ACK_WAIT.
- IDLE:
  - A byte equal to SYNC_BYTE moves the FSM to ADDR.
  - Any other byte is discarded silently.
- ADDR, DHI, DLO:
  - Each state latches its byte on `i_Rx_DV` and advances to the next state.
  - The timeout counter reloads on entry to each state and on every `i_Rx_DV`.
  - If the counter expires (TIMEOUT_CLKS cycles with no byte), the FSM returns to IDLE. No response is sent and no SPI activity occurs.
- Leaving DLO:
  - If ADDR[7] = 0, go to SHIFT.
  - If ADDR[7] = 1 (reserved address), skip SHIFT, set response = 8'h15 (NAK), and go to ACK.
- SHIFT:
  - Shifts out the 24-bit frame {ADDR, DATA_HI, DATA_LO}.
  - On completion, `o_Write_Count` increments, response = 8'h06 (ACK), and the FSM goes to ACK.
- ACK: waits until `i_Tx_Active` = 0, then pulses `o_Tx_DV` for one cycle and goes to ACK_WAIT.
- ACK_WAIT: on `i_Tx_Done`, returns to IDLE.
- `i_Rx_DV` in SHIFT, ACK or ACK_WAIT: the byte is dropped. It is never counted as a SYNC.
- Reset values: `o_SEN`=1, `o_SCK`=0, `o_SDAT`=0, `o_Tx_DV`=0, `o_Tx_Byte`=8'h00, `o_Busy`=0, `o_Write_Count`=0, state IDLE.
- Reset asserted mid-frame: SEN returns high and SCK returns low immediately (asynchronous reset). No partial-write completion is signalled.

## Timing
- Let N be the cycle in which `i_Rx_DV` carries DATA_LO. The FSM state is SHIFT from cycle N+1.
- Let T0 = N+1. All SPI outputs are registered.
- At T0, `o_SEN` falls and `o_SDAT` = bit 23.
- Rising edge k (k = 0..23) of `o_SCK` occurs at T0+(2k+1)·H. The following falling edge occurs at T0+(2k+2)·H.
- `o_SDAT` updates only at falling edges (bit 23−(k+1)), so it is stable across each rising edge.
- At T0+49·H: `o_SEN` rises, `o_SDAT` returns to 0, and `o_Write_Count` increments in the same cycle.
- `o_SEN` is low for exactly 49·H cycles.
- ACK state is entered at T0+49·H+1. `o_Tx_DV` pulses in that same cycle if `i_Tx_Active` = 0.
- NAK path: ACK is entered at N+1.
- `o_Busy` rises in the cycle after the SYNC strobe. It falls in the cycle after `i_Tx_Done` or the timeout.

## Structure
- Shared package `bluejay_pkg`:
  - State enum.
  - ACK (8'h06) and NAK (8'h15) constants.
  - Frame length (24).
  - Reserved-address bit index (7).
- Sub-module `bluejay_spi_shift` contains the H divider, the 24-bit shift register and the SEN/SCK/SDAT generation.
  - Handshake: `i_Start` / `o_Done`; `o_Done` is a one-cycle strobe at T0+49·H.
  - The parent holds the FSM, the timeout counter, the response register and `o_Write_Count`.

## Test plan
- Basic write: with H=2, send A5 12 34 56. Expect SEN low for 98 cycles, SDAT pattern 0x123456 sampled on the 24 SCK rises, one `o_Tx_DV` with byte 06, and `o_Write_Count`=1.
- Reserved address: send A5 80 00 01. Expect no SEN activity, response 15, and `o_Write_Count` unchanged.
- Garbage and timeout: send 00 FF (discarded), then A5 12 with a gap of TIMEOUT_CLKS+1 cycles, then 34 56 A5 01 02 03. Expect exactly one write, of 0x010203.
- Busy TX: hold `i_Tx_Active`=1 for 500 cycles after the frame ends. Expect `o_Tx_DV` to be withheld, then a single pulse once `i_Tx_Active` falls.
- Drops and wrap: inject `i_Rx_DV`=A5 during SHIFT and check it is ignored. Preload the counter to FFFF with 65535 writes (or force) and check the next write wraps it to 0000.
- Reset mid-frame: assert `i_Reset` at T0+20. Expect SEN=1 and SCK=0 immediately, `o_Busy`=0, and no `o_Tx_DV`.
